// File: rtl/msdf_pkg.sv
// Shared types and helpers for the MSDF on-the-fly converter.
// Digit decode, FSM state encoding and Q/QM reset constants.
package msdf_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSkip,
    StAcc,
    StDone
  } msdf_state_t;

  localparam int QResetVal  = 0;
  localparam int QmResetVal = -1;

  // Rails to a signed digit: (1,0)=+1, (0,1)=-1, (0,0)/(1,1)=0.
  function automatic logic signed [1:0] msdf_decode(input logic p, input logic n);
    case ({p, n})
      2'b10:   return 2'sb01;
      2'b01:   return 2'sb11;
      default: return 2'sb00;
    endcase
  endfunction

endpackage

// File: rtl/otf_step.sv
// Combinational single-digit Q/QM on-the-fly conversion step.
// Appends one radix-2 signed digit without carry propagation.
module otf_step #(
  parameter int unsigned W = 9
) (
  input  logic        [W-1:0] q,
  input  logic        [W-1:0] qm,
  input  logic signed [1:0]   d,
  output logic        [W-1:0] q_next,
  output logic        [W-1:0] qm_next
);

  always_comb begin
    q_next  = {q[W-2:0], 1'b0};
    qm_next = {qm[W-2:0], 1'b1};
    case (d)
      2'sb01: begin
        q_next  = {q[W-2:0], 1'b1};
        qm_next = {q[W-2:0], 1'b0};
      end
      2'sb11: begin
        q_next  = {qm[W-2:0], 1'b1};
        qm_next = {qm[W-2:0], 1'b0};
      end
      default: begin
        q_next  = {q[W-2:0], 1'b0};
        qm_next = {qm[W-2:0], 1'b1};
      end
    endcase
  end

endmodule

// File: rtl/msdf_otf_conv.sv
// MSDF digit stream to parallel two's-complement word, with leading-digit skip.
// Optional MSDF_SKIP_CHECK_EN adds a sticky skip_err flag for misaligned producers.
module msdf_otf_conv
  import msdf_pkg::*;
#(
  parameter int unsigned N    = 8,
  parameter int unsigned SKIP = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         in_p,
  input  logic         in_n,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N:0]   q,
  output logic         out_valid,
  input  logic         out_ready
`ifdef MSDF_SKIP_CHECK_EN
  ,
  output logic         skip_err
`endif
);

  localparam int unsigned W  = N + 1;
  localparam int unsigned CW = $clog2(SKIP + N + 1);

  msdf_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  q_q, q_d, qm_q, qm_d;

  logic              frame_start;
  logic              active;
  logic              accept;
  logic signed [1:0] digit;
  logic [CW-1:0]     base_cnt, next_cnt;
  logic [W-1:0]      base_q, base_qm, step_q, step_qm;

  assign in_ready  = (state_q != StDone);
  assign out_valid = (state_q == StDone);
  assign q         = q_q;

  // start restarts the frame from any state but DONE; the same-cycle digit is digit 0.
  assign frame_start = start && (state_q != StDone);
  assign active      = frame_start || (state_q == StSkip) || (state_q == StAcc);
  assign accept      = in_valid && in_ready;
  assign digit       = msdf_decode(in_p, in_n);

  assign base_cnt = frame_start ? '0 : cnt_q;
  assign base_q   = frame_start ? W'(QResetVal) : q_q;
  assign base_qm  = frame_start ? W'(QmResetVal) : qm_q;

  otf_step #(
    .W(W)
  ) u_step (
    .q      (base_q),
    .qm     (base_qm),
    .d      (digit),
    .q_next (step_q),
    .qm_next(step_qm)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    q_d      = q_q;
    qm_d     = qm_q;
    next_cnt = base_cnt;
    if (state_q == StDone) begin
      if (out_ready) begin
        state_d = StIdle;
      end
    end else if (active) begin
      q_d  = base_q;
      qm_d = base_qm;
      if (accept) begin
        next_cnt = base_cnt + CW'(1);
        if (base_cnt >= CW'(SKIP)) begin
          q_d  = step_q;
          qm_d = step_qm;
        end
      end
      cnt_d = next_cnt;
      // Next state follows purely from how many digits of the frame are consumed.
      if (next_cnt == CW'(SKIP + N)) begin
        state_d = StDone;
      end else if (next_cnt >= CW'(SKIP)) begin
        state_d = StAcc;
      end else begin
        state_d = StSkip;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      q_q     <= W'(QResetVal);
      qm_q    <= W'(QmResetVal);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      qm_q    <= qm_d;
    end
  end

`ifdef MSDF_SKIP_CHECK_EN
  logic skip_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      skip_err_q <= 1'b0;
    end else if (active && accept && (base_cnt < CW'(SKIP)) && (digit != 2'sb00)) begin
      skip_err_q <= 1'b1;
    end
  end

  assign skip_err = skip_err_q;
`endif

endmodule

// File: tb/tb_msdf_otf_conv.sv
// Self-checking bench for msdf_otf_conv: directed scenarios plus randomized frames.
// Set MSDF_SKIP_CHECK_EN to also exercise the skip_err flag.
module tb_msdf_otf_conv;

  localparam int N    = 8;
  localparam int SKIP = 3;
  localparam int L    = SKIP + N;

  typedef int frame_t [L];

  logic       clk = 1'b0;
  logic       rst, start, in_p, in_n, in_valid, out_ready;
  logic       in_ready, out_valid;
  logic [N:0] q;
`ifdef MSDF_SKIP_CHECK_EN
  logic       skip_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  msdf_otf_conv #(
    .N   (N),
    .SKIP(SKIP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_p     (in_p),
    .in_n     (in_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .q        (q),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef MSDF_SKIP_CHECK_EN
    ,
    .skip_err (skip_err)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Zero digits alternate randomly between the two zero encodings.
  task automatic set_digit(input int d);
    if (d > 0) begin
      in_p = 1'b1; in_n = 1'b0;
    end else if (d < 0) begin
      in_p = 1'b0; in_n = 1'b1;
    end else if ($urandom_range(1) == 0) begin
      in_p = 1'b0; in_n = 1'b0;
    end else begin
      in_p = 1'b1; in_n = 1'b1;
    end
  endtask

  // Value of the result digits as an integer scaled by 2^N.
  function automatic logic [N:0] model(input frame_t fr);
    int acc = 0;
    for (int i = 0; i < N; i++) acc = acc * 2 + fr[SKIP + i];
    return acc[N:0];
  endfunction

  function automatic frame_t rand_frame();
    frame_t fr;
    for (int i = 0; i < L; i++) fr[i] = int'($urandom_range(0, 2)) - 1;
    return fr;
  endfunction

  task automatic run_frame(input frame_t fr, input bit gaps, input string tag);
    logic [N:0] exp_q;
    int g;
    exp_q = model(fr);
    for (int i = 0; i < L; i++) begin
      g = (gaps && i > 0 && $urandom_range(3) == 0) ? int'($urandom_range(1, 2)) : 0;
      for (int j = 0; j < g; j++) begin
        start = 1'b0; in_valid = 1'b0; set_digit(int'($urandom_range(0, 2)) - 1);
        step();
      end
      if (i == L - 1) chk({tag, "_ov_before_last"}, out_valid, 1'b0);
      start = (i == 0); in_valid = 1'b1; set_digit(fr[i]);
      step();
    end
    start = 1'b0; in_valid = 1'b0;
    chk({tag, "_out_valid"}, out_valid, 1'b1);
    chk({tag, "_q"}, q, exp_q);
    chk({tag, "_in_ready_done"}, in_ready, 1'b0);
  endtask

  task automatic accept_out(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_ov_after_accept"}, out_valid, 1'b0);
    chk({tag, "_ir_after_accept"}, in_ready, 1'b1);
  endtask

  initial begin
    frame_t     f;
    logic [N:0] held;

    rst = 1'b1; start = 1'b0; in_p = 1'b0; in_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    step();
    start = 1'b1; in_valid = 1'b1; set_digit(1);
    step();
    chk("rst_q", q, '0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
`ifdef MSDF_SKIP_CHECK_EN
    chk("rst_skip_err", skip_err, 1'b0);
`endif
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    step();

    // Directed example: 97/256.
    f = '{0, 0, 0, 1, 0, -1, 0, 0, 0, 0, 1};
    run_frame(f, 1'b0, "ex97");
    chk("ex97_const", q, 9'h061);
    accept_out("ex97");

    for (int i = 0; i < L; i++) f[i] = (i < SKIP) ? 0 : -1;
    run_frame(f, 1'b0, "all_neg");
    chk("all_neg_const", q, 9'h101);
    accept_out("all_neg");

    for (int i = 0; i < L; i++) f[i] = (i < SKIP) ? 0 : 1;
    run_frame(f, 1'b0, "all_pos");
    chk("all_pos_const", q, 9'h0FF);
`ifdef MSDF_SKIP_CHECK_EN
    chk("clean_skip_err", skip_err, 1'b0);
`endif
    // Back-pressure: DONE holds, start and digits are ignored.
    held = q;
    for (int k = 0; k < 5; k++) begin
      start = k[0]; in_valid = 1'b1; set_digit(1);
      step();
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_q", q, held);
      chk("bp_in_ready", in_ready, 1'b0);
    end
    start = 1'b0; in_valid = 1'b0;
    accept_out("bp");

    // Abort after four ACC digits, then restart with a fresh frame.
    start = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < SKIP + 4; i++) begin
      set_digit(int'($urandom_range(0, 2)) - 1);
      step();
      start = 1'b0;
    end
    chk("abort_ov_mid", out_valid, 1'b0);
    f = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    run_frame(f, 1'b0, "abort");
    chk("abort_const", q, 9'h080);
    accept_out("abort");

    // Reset mid-ACC dominates start/in_valid.
    start = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < SKIP + 2; i++) begin
      set_digit(1);
      step();
      start = 1'b0;
    end
    rst = 1'b1; start = 1'b1; in_valid = 1'b1; set_digit(1);
    step();
    rst = 1'b0; start = 1'b0;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_q", q, '0);
    chk("midrst_in_ready", in_ready, 1'b1);
    // Digits without start are dropped in IDLE.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; set_digit(-1);
      step();
    end
    in_valid = 1'b0;
    chk("idle_drop_ov", out_valid, 1'b0);
    f = '{1, 0, -1, 1, 0, 0, 1, 0, -1, 0, 0};
    run_frame(f, 1'b0, "post_rst");
    accept_out("post_rst");
    in_valid = 1'b1; in_p = 1'b1; in_n = 1'b1; start = 1'b1;
    f = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < L; i++) begin
      step();
      start = 1'b0;
    end
    in_valid = 1'b0;
    chk("both_rails_ov", out_valid, 1'b1);
    chk("both_rails_q", q, model(f));
    accept_out("both_rails");

`ifdef MSDF_SKIP_CHECK_EN
    f = '{0, 1, 0, 1, 1, 0, 0, 0, 0, 0, -1};
    run_frame(f, 1'b0, "skerr");
    chk("skerr_set", skip_err, 1'b1);
    accept_out("skerr");
    for (int i = 0; i < L; i++) f[i] = (i < SKIP) ? 0 : 1;
    run_frame(f, 1'b0, "skerr_sticky");
    chk("skerr_sticky_flag", skip_err, 1'b1);
    accept_out("skerr_sticky");
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("skerr_cleared", skip_err, 1'b0);
`endif

    // Randomized frames with input gaps and variable consumer delay.
    for (int t = 0; t < 12; t++) begin
      f = rand_frame();
      run_frame(f, 1'b1, "rand");
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        step();
        chk("rand_hold_ov", out_valid, 1'b1);
      end
      accept_out("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
